// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, branch flush, hold,
// WB-to-ID register bypass and saturating stall/flush event counters.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   hold, flush         global freeze; wrong-path squash of the ID instruction
//   IF_ID_*/ID_*        register fields, operands and control of the ID instr
//   MEM_WB_*, WB_Data   register-file write port, used for the WB bypass
//   ID_EX_*             registered bundle consumed by forwarding and EX
//   stall               combinational; freezes PC and IF/ID
//   stall_cnt/flush_cnt saturating event counters
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [4:0]        IF_ID_RS,
    input  logic [4:0]        IF_ID_RT,
    input  logic [4:0]        IF_ID_RD,
    input  logic              ID_UsesRt,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PC4,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic              ID_isR,
    input  logic [3:0]        ID_ALUOp,
    input  logic              MEM_WB_RegWrite,
    input  logic [4:0]        MEM_WB_RD,
    input  logic [DATA_W-1:0] WB_Data,
    output logic [4:0]        ID_EX_RS,
    output logic [4:0]        ID_EX_RT,
    output logic [4:0]        ID_EX_RD,
    output logic [DATA_W-1:0] ID_EX_A,
    output logic [DATA_W-1:0] ID_EX_B,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PC4,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic              ID_EX_isR,
    output logic [3:0]        ID_EX_ALUOp,
    output logic              ID_EX_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              memto_reg;
        logic              alu_src;
        logic              reg_dst;
        logic              is_r;
        logic [3:0]        alu_op;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu;
    logic             wb_hit_a, wb_hit_b;
    logic [DATA_W-1:0] a_in, b_in;

    // Stores read rt only as memory data; that path is covered downstream,
    // so rt only matters when ID_UsesRt marks it as an ALU/compare source.
    assign lu = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0)
              & ((ex_q.rt == IF_ID_RS)
               | (ID_UsesRt & (ex_q.rt == IF_ID_RT)));

    assign stall = lu & ~flush & ~hold;

    // Register file is written at the end of the cycle, so same-cycle reads
    // would return stale data without this bypass. $0 is never bypassed.
    assign wb_hit_a = MEM_WB_RegWrite & (MEM_WB_RD != 5'd0)
                    & (MEM_WB_RD == IF_ID_RS);
    assign wb_hit_b = MEM_WB_RegWrite & (MEM_WB_RD != 5'd0)
                    & (MEM_WB_RD == IF_ID_RT);
    assign a_in = wb_hit_a ? WB_Data : ID_ReadData1;
    assign b_in = wb_hit_b ? WB_Data : ID_ReadData2;

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold) begin
            ex_d = ex_q;
        end else if (flush) begin
            ex_d = '0;
            if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (lu) begin
            ex_d = '0;
            if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = IF_ID_RS;
            ex_d.rt        = IF_ID_RT;
            ex_d.rd        = IF_ID_RD;
            ex_d.a         = a_in;
            ex_d.b         = b_in;
            ex_d.imm       = ID_Imm;
            ex_d.pc4       = ID_PC4;
            ex_d.reg_write = ID_RegWrite;
            ex_d.mem_read  = ID_MemRead;
            ex_d.mem_write = ID_MemWrite;
            ex_d.memto_reg = ID_MemtoReg;
            ex_d.alu_src   = ID_ALUSrc;
            ex_d.reg_dst   = ID_RegDst;
            ex_d.is_r      = ID_isR;
            ex_d.alu_op    = ID_ALUOp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ID_EX_valid    = ex_q.valid;
    assign ID_EX_RS       = ex_q.rs;
    assign ID_EX_RT       = ex_q.rt;
    assign ID_EX_RD       = ex_q.rd;
    assign ID_EX_A        = ex_q.a;
    assign ID_EX_B        = ex_q.b;
    assign ID_EX_Imm      = ex_q.imm;
    assign ID_EX_PC4      = ex_q.pc4;
    assign ID_EX_RegWrite = ex_q.reg_write;
    assign ID_EX_MemRead  = ex_q.mem_read;
    assign ID_EX_MemWrite = ex_q.mem_write;
    assign ID_EX_MemtoReg = ex_q.memto_reg;
    assign ID_EX_ALUSrc   = ex_q.alu_src;
    assign ID_EX_RegDst   = ex_q.reg_dst;
    assign ID_EX_isR      = ex_q.is_r;
    assign ID_EX_ALUOp    = ex_q.alu_op;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the forwarding unit.
- Registers decoded operands, register numbers and control into the ID_EX_* signals consumed by forwarding and EX.
- Detects load-use hazards and inserts bubbles; handles branch flush and whole-pipe hold.
- Applies WB-to-ID register-file bypass.
- Keeps saturating stall and flush event counters.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze, e.g. memory wait; ID_EX contents retained.
- flush  in  1  taken branch or jump resolved downstream; ID instruction is wrong-path.
- IF_ID_RS, IF_ID_RT, IF_ID_RD  in  5 each  register fields of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as an ALU/compare source (R-type or branch). Stores and other I-types drive 0.
- ID_ReadData1, ID_ReadData2  in  DATA_W each  register-file read data.
- ID_Imm, ID_PC4  in  DATA_W each  sign-extended immediate; PC+4.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_isR  in  1 each  decoded control.
- ID_ALUOp  in  4  ALU operation.
- MEM_WB_RegWrite  in  1  WB stage writes the register file.
- MEM_WB_RD  in  5  WB destination register.
- WB_Data  in  DATA_W  WB write data.
- ID_EX_RS, ID_EX_RT, ID_EX_RD  out  5 each  registered register fields.
- ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_PC4  out  DATA_W each  registered operands.
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_isR  out  1 each  registered control.
- ID_EX_ALUOp  out  4  registered ALU operation.
- ID_EX_valid  out  1  1 = real instruction in EX; 0 = bubble.
- stall  out  1  combinational; deasserts PC and IF_ID write enables.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (asynchronous, immediate): every registered output and both counters go to 0, so ID_EX_valid=0 (bubble).
  - stall is combinational and therefore reads 0 while in reset.
- Load-use detect (combinational): lu = ID_EX_valid & ID_EX_MemRead & (ID_EX_RT!=0) & ((ID_EX_RT==IF_ID_RS) | (ID_UsesRt & ID_EX_RT==IF_ID_RT)).
  - Store data dependence on rt is not a hazard; the downstream lw->sw path covers it.
- stall = lu & ~flush & ~hold.
- WB bypass:
  - A_in = WB_Data if MEM_WB_RegWrite & MEM_WB_RD!=0 & MEM_WB_RD==IF_ID_RS; otherwise ID_ReadData1.
  - B_in is the same rule using IF_ID_RT and ID_ReadData2.
  - Register 0 is never bypassed.
- Per-edge priority (first match wins):
  1. hold: all ID_EX_* unchanged; counters unchanged.
  2. flush: load a bubble; flush_cnt += 1.
  3. lu: load a bubble; stall_cnt += 1.
  4. otherwise: load all ID inputs with A_in/B_in; ID_EX_valid=1.
- Bubble definition:
  - Zeroed: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, isR, ALUOp, valid, and RS/RT/RD.
  - A/B/Imm/PC4 are don't-care; they are driven to 0.
- Stall duration: one load-use stalls exactly one cycle.
  - The bubble clears ID_EX_MemRead, so lu drops on the next cycle.
  - The stalled instruction is then loaded; WB bypass supplies the load result if it is in WB at that edge.
- flush with a concurrent lu: stall=0 and one bubble is inserted; only flush_cnt increments.
- Counters saturate at all-ones; no wrap.
- Reset mid-stall: the bubble state is restored immediately and stall falls to 0 with no extra cycle.

Test Plan:
- Reset release, no hold/flush, ID presents RS=3, RT=4, ReadData1=0x11, ALUOp=2, RegWrite=1 -> next edge ID_EX_RS=3, ID_EX_A=0x11, ID_EX_valid=1, stall=0 throughout.
- lw $5 in EX (MemRead=1, RT=5); ID add with RS=5 -> stall=1 for exactly one cycle; next edge ID_EX_valid=0, ID_EX_RegWrite=0, stall_cnt=1; following edge the add loads with valid=1.
- lw $5 in EX; ID sw with RT=5, ID_UsesRt=0 -> stall=0, no bubble. Repeat with ID_EX_RT=0 and IF_ID_RS=0 -> stall=0.
- lu condition and flush=1 on the same cycle -> stall=0, bubble loaded, flush_cnt=1, stall_cnt=0. hold=1 with lu -> stall=0, ID_EX contents and counters unchanged.
- MEM_WB_RegWrite=1, MEM_WB_RD=7, WB_Data=0xDEAD, IF_ID_RS=IF_ID_RT=7, ReadData=0 -> ID_EX_A=ID_EX_B=0xDEAD. Repeat with RD=0 -> ID_EX_A=0.
- Force stall_cnt to all-ones via 65535 lu events, then one more -> stays 0xFFFF. Assert rst mid-sequence -> all outputs 0 asynchronously.
